// File: rtl/spi_frame_if.sv
// spi_frame_if: SPI frame deserialiser/serialiser sitting in front of the Ascon core.
// Rev 1.0
`default_nettype none

module spi_frame_if #(
  parameter int WORD_W = 64,
  parameter int CNT_W  = 8
) (
  input  logic              interface_clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              sdi,
  output logic              sdo,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [3:0]        out_type,
  output logic              out_last,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [WORD_W-1:0] rd_data,
  output logic              frame_abort,
  output logic              overflow,
  output logic              underrun,
  output logic              busy
);

  localparam int BIT_W = $clog2(WORD_W);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_W - 1);
  localparam logic [BIT_W-1:0] BYTE_LAST = BIT_W'(7);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_OPCODE = 3'd1;
  localparam logic [2:0] S_COUNT  = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_READ   = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;

  logic [2:0]        state, next_state;
  logic [WORD_W-2:0] sr;
  logic [WORD_W-1:0] rsr;
  logic [BIT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  rem;
  logic [3:0]        typ;
  logic              armed;

  logic [7:0]        in_byte;
  logic [WORD_W-1:0] word_in;
  logic              field_end, word_end, write_done, read_bound, load_pt, abort_cond;

  assign in_byte    = {sr[6:0], sdi};
  assign word_in    = {sr, sdi};
  assign field_end  = (bit_cnt == BYTE_LAST);
  assign word_end   = (bit_cnt == BIT_LAST);
  assign write_done = !cs_n && (state == S_WRITE) && word_end;
  assign read_bound = !cs_n && (state == S_READ) && word_end;
  // Read words are fetched on the last count edge and on every later word boundary that stays in READ.
  assign load_pt    = (next_state == S_READ) &&
                      (((state == S_COUNT) && field_end) || ((state == S_READ) && word_end));
  assign abort_cond = cs_n && ((state == S_OPCODE) || (state == S_COUNT) ||
                      (((state == S_WRITE) || (state == S_READ)) && (bit_cnt != '0)));

  always_ff @(posedge interface_clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (cs_n) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (armed) next_state = S_OPCODE;
        S_OPCODE: if (field_end) next_state = S_COUNT;
        S_COUNT: begin
          if (field_end) begin
            if (in_byte == 8'd0)                   next_state = S_DRAIN;
            else if (typ == 4'hF)                  next_state = S_READ;
            else if (typ >= 4'h1 && typ <= 4'h4)   next_state = S_WRITE;
            else                                   next_state = S_DRAIN;
          end
        end
        S_WRITE,
        S_READ:   if (word_end && rem == CNT_W'(1)) next_state = S_DRAIN;
        S_DRAIN:  next_state = S_DRAIN;
        default:  next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    sdo      = 1'b0;
    busy     = (state != S_IDLE);
    rd_ready = load_pt && rd_valid;
    if (state == S_READ) sdo = rsr[WORD_W-1];
  end

  always_ff @(posedge interface_clk) begin
    if (rst) begin
      sr          <= '0;
      rsr         <= '0;
      bit_cnt     <= '0;
      rem         <= '0;
      typ         <= '0;
      armed       <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_type    <= '0;
      out_last    <= 1'b0;
      frame_abort <= 1'b0;
      overflow    <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_abort <= abort_cond;
      if (cs_n) armed <= 1'b1;
      if (!cs_n) sr <= word_in[WORD_W-2:0];

      if (cs_n) begin
        bit_cnt <= '0;
      end else begin
        case (state)
          S_IDLE:           bit_cnt <= armed ? BIT_W'(1) : '0;
          S_OPCODE, S_COUNT: bit_cnt <= field_end ? '0 : bit_cnt + BIT_W'(1);
          S_WRITE, S_READ:  bit_cnt <= bit_cnt + BIT_W'(1);
          default:          bit_cnt <= '0;
        endcase
      end

      if (!cs_n && state == S_OPCODE && field_end) typ <= in_byte[7:4];
      if (!cs_n && state == S_COUNT && field_end)  rem <= CNT_W'(in_byte);
      if (write_done || read_bound)                rem <= rem - CNT_W'(1);

      // A completed word may replace the pending one only if that one leaves on this edge.
      if (write_done) begin
        if (out_valid && !out_ready) begin
          overflow <= 1'b1;
        end else begin
          out_valid <= 1'b1;
          out_data  <= word_in;
          out_type  <= typ;
          out_last  <= (rem == CNT_W'(1));
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (load_pt) begin
        rsr <= rd_valid ? rd_data : '0;
        if (!rd_valid) underrun <= 1'b1;
      end else if (state == S_READ) begin
        rsr <= {rsr[WORD_W-2:0], 1'b0};
      end
    end
  end

endmodule

`default_nettype wire
